// File: rtl/stump_sequencer.sv
// stump_sequencer
// Sequencing stage in front of the Stump control decoder. It holds the
// FETCH / EXECUTE / MEMORY state machine, the instruction register (ir) and
// the condition-code register (cc). It stretches FETCH and MEMORY while memory
// is not ready, and it counts retired instructions.
//
// Optional build macro: STUMP_SINGLE_STEP_EN
//   When it is defined, the design has an extra input `step`. FETCH then
//   advances only on an edge where mem_ready and step are both high. A
//   one-cycle step pulse runs exactly one instruction. Holding step high runs
//   freely.
//
// Handshake: mem_ready works as a one-sided completion strobe. A FETCH or
// MEMORY access finishes on the rising edge where mem_ready=1 is sampled.
// While the machine waits, stall is high. There is no back-pressure toward
// memory. EXECUTE ignores mem_ready.
module stump_sequencer #(
   parameter int          CNT_WIDTH = 16,
   parameter logic [15:0] IR_RESET  = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          mem_rdata,
   input  logic                 mem_ready,
   input  logic                 cc_en,
   input  logic [3:0]           cc_in,
`ifdef STUMP_SINGLE_STEP_EN
   input  logic                 step,
`endif
   output logic [1:0]           state,
   output logic [15:0]          ir,
   output logic [3:0]           cc,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] instr_count
);

   // State encoding. The decoder downstream sees these values directly.
   localparam logic [1:0] S_FETCH   = 2'b00;
   localparam logic [1:0] S_EXECUTE = 2'b01;
   localparam logic [1:0] S_MEMORY  = 2'b10;
   localparam logic [1:0] S_ILLEGAL = 2'b11;

   // ir[15:13] opcode class that needs a data-memory cycle
   localparam logic [2:0] OP_LDST   = 3'b011;

   logic [1:0]           state_q, state_d;
   logic [15:0]          ir_q, ir_d;
   logic [3:0]           cc_q, cc_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic                 in_fetch;
   logic                 in_execute;
   logic                 in_memory;
   logic                 fetch_go;
   logic                 is_ldst;
   logic                 retire;

   // One-hot style views of the current state
   always_comb begin
      in_fetch   = (state_q == S_FETCH);
      in_execute = (state_q == S_EXECUTE);
      in_memory  = (state_q == S_MEMORY);
      is_ldst    = (ir_q[15:13] == OP_LDST);
   end

   // Condition for leaving FETCH. With single-step, a step pulse also gates it.
`ifdef STUMP_SINGLE_STEP_EN
   always_comb begin
      fetch_go = mem_ready && step;
   end
`else
   always_comb begin
      fetch_go = mem_ready;
   end
`endif

   // Stall is combinational. FETCH waits on fetch_go, MEMORY waits on mem_ready.
   always_comb begin
      stall = (in_fetch && !fetch_go) || (in_memory && !mem_ready);
   end

   // Next state, ir load and retire strobe
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (fetch_go) begin
               state_d = S_EXECUTE;
               ir_d    = mem_rdata;
            end
         end
         S_EXECUTE: begin
            if (is_ldst) begin
               state_d = S_MEMORY;
            end else begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_MEMORY: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_ILLEGAL: begin
            // Recovers to FETCH and does not count as a retirement
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Flags load only on an EXECUTE edge that has cc_en. The load happens on
   // the same edge as the state change.
   always_comb begin
      cc_d = cc_q;
      if (in_execute && cc_en) begin
         cc_d = cc_in;
      end
   end

   // Retired-instruction counter. It wraps silently at all-ones.
   always_comb begin
      count_d = count_q;
      if (retire) begin
         count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // State registers with an asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= IR_RESET;
         cc_q    <= 4'b0000;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
         count_q <= count_d;
      end
   end

   // Outputs come straight from the registers
   always_comb begin
      state       = state_q;
      ir          = ir_q;
      cc          = cc_q;
      instr_count = count_q;
   end

endmodule

// File: tb/tb_stump_sequencer.sv
// tb_stump_sequencer
// Directed bench for stump_sequencer. The default-width instance and a
// CNT_WIDTH=4 instance share the same stimulus. The narrow instance exercises
// the counter wrap. Build with STUMP_SINGLE_STEP_EN to add the single-step
// steps.
module tb_stump_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        cc_en;
   logic [3:0]  cc_in;
   logic        step;

   logic [1:0]  state,  state4;
   logic [15:0] ir,     ir4;
   logic [3:0]  cc,     cc4;
   logic        stall,  stall4;
   logic [15:0] instr_count;
   logic [3:0]  instr_count4;

   int vectors;
   int fails;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   stump_sequencer #(.CNT_WIDTH(16), .IR_RESET(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .cc_en       (cc_en),
      .cc_in       (cc_in),
`ifdef STUMP_SINGLE_STEP_EN
      .step        (step),
`endif
      .state       (state),
      .ir          (ir),
      .cc          (cc),
      .stall       (stall),
      .instr_count (instr_count)
   );

   stump_sequencer #(.CNT_WIDTH(4), .IR_RESET(16'h0000)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .cc_en       (cc_en),
      .cc_in       (cc_in),
`ifdef STUMP_SINGLE_STEP_EN
      .step        (step),
`endif
      .state       (state4),
      .ir          (ir4),
      .cc          (cc4),
      .stall       (stall4),
      .instr_count (instr_count4)
   );

   // ---------------- driver / checker tasks ----------------
   // Advance one clock and sample 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the core outputs of both instances against one expectation
   task automatic chk_all(input string tag, input logic [1:0] e_state, input logic [15:0] e_ir,
                          input logic [3:0] e_cc, input logic e_stall,
                          input logic [15:0] e_cnt);
      chk({tag, ".state"},  {30'd0, state},        {30'd0, e_state});
      chk({tag, ".ir"},     {16'd0, ir},           {16'd0, e_ir});
      chk({tag, ".cc"},     {28'd0, cc},           {28'd0, e_cc});
      chk({tag, ".stall"},  {31'd0, stall},        {31'd0, e_stall});
      chk({tag, ".cnt"},    {16'd0, instr_count},  {16'd0, e_cnt});
      chk({tag, ".state4"}, {30'd0, state4},       {30'd0, e_state});
      chk({tag, ".cnt4"},   {28'd0, instr_count4}, {28'd0, e_cnt[3:0]});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [15:0] word;
      logic [15:0] exp_cnt;
      vectors   = 0;
      fails     = 0;
      rst       = 1'b1;
      mem_rdata = 16'h0000;
      mem_ready = 1'b0;
      cc_en     = 1'b0;
      cc_in     = 4'b0000;
      step      = 1'b1;

      // Reset state. mem_ready=0 in FETCH, so stall=1.
      tick();
      tick();
      chk_all("reset", 2'b00, 16'h0000, 4'b0000, 1'b1, 16'd0);
      rst = 1'b0;

      // ADD with no wait states: 00 -> 01 -> 00
      mem_rdata = 16'h0A44;
      mem_ready = 1'b1;
      #1;
      chk_all("add.fetch", 2'b00, 16'h0000, 4'b0000, 1'b0, 16'd0);
      tick();
      mem_ready = 1'b0;     // EXECUTE must not stall on this
      mem_rdata = 16'hFFFF; // ir must not pick this up
      #1;
      chk_all("add.exec", 2'b01, 16'h0A44, 4'b0000, 1'b0, 16'd0);
      tick();
      chk_all("add.done", 2'b00, 16'h0A44, 4'b0000, 1'b1, 16'd1);

      // LDST with two wait cycles in MEMORY: 00,01,10,10,10,00
      mem_rdata = 16'h6120;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk_all("ldst.exec", 2'b01, 16'h6120, 4'b0000, 1'b0, 16'd1);
      tick();
      chk_all("ldst.mem1", 2'b10, 16'h6120, 4'b0000, 1'b1, 16'd1);
      tick();
      chk_all("ldst.mem2", 2'b10, 16'h6120, 4'b0000, 1'b1, 16'd1);
      tick();
      mem_ready = 1'b1;
      #1;
      chk_all("ldst.mem3", 2'b10, 16'h6120, 4'b0000, 1'b0, 16'd1);
      mem_ready = 1'b0;
      #1;
      chk_all("ldst.mem3b", 2'b10, 16'h6120, 4'b0000, 1'b1, 16'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk_all("ldst.done", 2'b00, 16'h6120, 4'b0000, 1'b1, 16'd2);

      // CC gating: cc_en ignored in FETCH, applied on the EXECUTE edge
      mem_rdata = 16'h0A44;
      cc_en     = 1'b1;
      cc_in     = 4'b1010;
      tick();
      chk_all("cc.fetch_wait", 2'b00, 16'h6120, 4'b0000, 1'b1, 16'd2);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk_all("cc.exec", 2'b01, 16'h0A44, 4'b0000, 1'b0, 16'd2);
      tick();
      chk_all("cc.after", 2'b00, 16'h0A44, 4'b1010, 1'b1, 16'd3);
      chk("cc4.after", {28'd0, cc4}, 32'h0000000A);
      // New flags offered in FETCH are ignored
      cc_in = 4'b0101;
      tick();
      chk_all("cc.fetch_ign", 2'b00, 16'h0A44, 4'b1010, 1'b1, 16'd3);
      // EXECUTE with cc_en=0 keeps the old flags
      mem_rdata = 16'h2B00;
      mem_ready = 1'b1;
      tick();
      cc_en = 1'b0;
      cc_in = 4'b1111;
      tick();
      chk_all("cc.noen", 2'b00, 16'h2B00, 4'b1010, 1'b0, 16'd4);
      // LDST: flags update on the EXECUTE->MEMORY edge
      mem_rdata = 16'h7001;
      tick();
      cc_en = 1'b1;
      cc_in = 4'b0110;
      mem_ready = 1'b0;
      tick();
      cc_en = 1'b0;
      #1;
      chk_all("cc.ldst_mem", 2'b10, 16'h7001, 4'b0110, 1'b1, 16'd4);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk_all("cc.ldst_done", 2'b00, 16'h7001, 4'b0110, 1'b1, 16'd5);

      // Reset mid-stall in MEMORY, applied between clock edges
      mem_rdata = 16'h6000;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("rst.pre_state", {30'd0, state}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk_all("rst.async", 2'b00, 16'h0000, 4'b0000, 1'b1, 16'd0);
      #1;
      rst = 1'b0;
      tick();
      chk_all("rst.release", 2'b00, 16'h0000, 4'b0000, 1'b1, 16'd0);

      // Counter wrap: 16 non-LDST instructions, 4-bit counter 15 -> 0
      mem_ready = 1'b1;
      exp_cnt   = 16'd0;
      for (int i = 0; i < 16; i++) begin
         word = {(i[2:0] == 3'b011) ? 3'b111 : i[2:0], 13'(i * 37 + 5)};
         mem_rdata = word;
         tick();
         chk("wrap.exec_state", {30'd0, state}, 32'd1);
         chk("wrap.ir", {16'd0, ir}, {16'd0, word});
         tick();
         exp_cnt = exp_cnt + 16'd1;
         chk("wrap.cnt", {16'd0, instr_count}, {16'd0, exp_cnt});
         chk("wrap.cnt4", {28'd0, instr_count4}, {28'd0, exp_cnt[3:0]});
      end
      chk_all("wrap.end", 2'b00, 16'h0000 | {3'b111, 13'(15 * 37 + 5)}, 4'b0000, 1'b0, 16'd16);

`ifdef STUMP_SINGLE_STEP_EN
      // Single-step: hold in FETCH while step=0, one pulse -> one retire
      mem_rdata = 16'h1234;
      mem_ready = 1'b1;
      step      = 1'b0;
      tick();
      chk_all("ss.hold1", 2'b00, 16'h0000 | {3'b111, 13'(15 * 37 + 5)}, 4'b0000, 1'b1, 16'd16);
      tick();
      chk_all("ss.hold2", 2'b00, 16'h0000 | {3'b111, 13'(15 * 37 + 5)}, 4'b0000, 1'b1, 16'd16);
      step = 1'b1;
      #1;
      chk("ss.pulse_stall", {31'd0, stall}, 32'd0);
      tick();
      step = 1'b0;
      #1;
      chk_all("ss.exec", 2'b01, 16'h1234, 4'b0000, 1'b0, 16'd16);
      tick();
      chk_all("ss.retired", 2'b00, 16'h1234, 4'b0000, 1'b1, 16'd17);
      tick();
      chk_all("ss.hold3", 2'b00, 16'h1234, 4'b0000, 1'b1, 16'd17);
      step = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
